// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] KB_NONE = 8'h00;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes both PS/2 pins and accepts a level only after FILTER_LEN
// identical samples; pulses fall_tick_o on each accepted clock 1->0 edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic data_o,
    output logic fall_tick_o
);

    // Index 0 is the PS/2 clock line, index 1 the data line.
    logic [1:0]                 meta_q;
    logic [1:0]                 sync_q;
    logic [1:0][FILTER_LEN-1:0] hist_q;
    logic [1:0]                 filt_q;
    logic                       fall_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
            hist_q <= '1;
            filt_q <= 2'b11;
            fall_q <= 1'b0;
        end else begin
            meta_q <= {ps2_data_i, ps2_clk_i};
            sync_q <= meta_q;
            for (int i = 0; i < 2; i++) begin
                hist_q[i] <= {hist_q[i][FILTER_LEN-2:0], sync_q[i]};
                if (&hist_q[i]) begin
                    filt_q[i] <= 1'b1;
                end else if (~|hist_q[i]) begin
                    filt_q[i] <= 1'b0;
                end
            end
            // Pulse in the same cycle the filtered clock drops to 0.
            fall_q <= filt_q[0] && (~|hist_q[0]);
        end
    end

    assign data_o      = filt_q[1];
    assign fall_tick_o = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames bytes, decodes E0/F0 prefixes and tracks
// the currently held key for the KB_CODE memory word.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kb_code,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic       data_s;
    logic       fall_tick;
    logic       stop_ok;

    ps2_state_t    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic          ext_q;
    logic          brk_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    kb_code_q;
    logic          ev_valid_q;
    logic [7:0]    ev_code_q;
    logic          ev_break_q;
    logic          ev_ext_q;
    logic          frame_err_q;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .data_o      (data_s),
        .fall_tick_o (fall_tick)
    );

    // NOTE: a default assignment at the top of always_comb keeps every path
    // driven, so no latch is inferred.
    always_comb begin
        stop_ok = 1'b0;
        if (data_s && (^{shift_q, parity_q})) begin
            stop_ok = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            tmo_q       <= '0;
            kb_code_q   <= KB_NONE;
            ev_valid_q  <= 1'b0;
            ev_code_q   <= 8'h00;
            ev_break_q  <= 1'b0;
            ev_ext_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ev_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (fall_tick) begin
                tmo_q <= '0;
                unique case (state_q)
                    IDLE: begin
                        if (!data_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= data_s;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!stop_ok) begin
                            frame_err_q <= 1'b1;
                            ext_q       <= 1'b0;
                            brk_q       <= 1'b0;
                        end else if (shift_q == PS2_EXT) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            brk_q <= 1'b1;
                        end else begin
                            ev_valid_q <= 1'b1;
                            ev_code_q  <= shift_q;
                            ev_break_q <= brk_q;
                            ev_ext_q   <= ext_q;
                            ext_q      <= 1'b0;
                            brk_q      <= 1'b0;
                            // A break only clears the held key if it names that key.
                            if (!brk_q) begin
                                kb_code_q <= shift_q;
                            end else if (shift_q == kb_code_q) begin
                                kb_code_q <= KB_NONE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q == IDLE) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_LAST) begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
                ext_q       <= 1'b0;
                brk_q       <= 1'b0;
                tmo_q       <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end
        end
    end

    assign kb_code   = kb_code_q;
    assign ev_valid  = ev_valid_q;
    assign ev_code   = ev_code_q;
    assign ev_break  = ev_break_q;
    assign ev_ext    = ev_ext_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx with a scaled-down PS/2 clock and timeout.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 200;
    localparam int HALF       = 20;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] kb_code;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    int         ev_cnt   = 0;
    int         err_cnt  = 0;
    int         err_wide = 0;
    int         both_cnt = 0;
    logic       prev_err = 1'b0;
    logic [7:0] last_code  = 8'h00;
    logic       last_break = 1'b0;
    logic       last_ext   = 1'b0;

    int ev_base;
    int err_base;

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kb_code   (kb_code),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_break  (ev_break),
        .ev_ext    (ev_ext),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ev_valid) begin
            ev_cnt     <= ev_cnt + 1;
            last_code  <= ev_code;
            last_break <= ev_break;
            last_ext   <= ev_ext;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (frame_err && prev_err) err_wide <= err_wide + 1;
        if (frame_err && ev_valid) both_cnt <= both_cnt + 1;
        prev_err <= frame_err;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit 0 of bits is the first bit sent (start bit).
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            wait_clks(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_parity);
        logic par;
        par = ~(^b) ^ bad_parity;
        send_bits({1'b1, par, b, 1'b0}, 11);
        wait_clks(HALF);
    endtask

    task automatic mark();
        @(negedge clk);
        ev_base  = ev_cnt;
        err_base = err_cnt;
    endtask

    initial begin
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clks(5);
        check("rst_kb_code", kb_code, 8'h00);
        check("rst_outputs", {ev_valid, ev_code, ev_break, ev_ext, frame_err}, 12'h000);
        reset = 1'b1;
        wait_clks(20);

        mark();
        send_byte(8'h23, 1'b0);
        check("make23_kb", kb_code, 8'h23);
        check("make23_evcnt", ev_cnt - ev_base, 1);
        check("make23_ev", {last_code, last_break, last_ext}, {8'h23, 2'b00});
        check("make23_noerr", err_cnt - err_base, 0);

        mark();
        send_byte(8'hF0, 1'b0);
        check("f0_alone_noev", ev_cnt - ev_base, 0);
        check("f0_alone_kb", kb_code, 8'h23);
        send_byte(8'h23, 1'b0);
        check("brk23_kb", kb_code, 8'h00);
        check("brk23_evcnt", ev_cnt - ev_base, 1);
        check("brk23_ev", {last_code, last_break, last_ext}, {8'h23, 2'b10});

        mark();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("ext75_kb", kb_code, 8'h75);
        check("ext75_ev", {ev_cnt - ev_base, last_code, last_break, last_ext}, {32'd1, 8'h75, 2'b01});

        mark();
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("extbrk75_kb", kb_code, 8'h00);
        check("extbrk75_ev", {ev_cnt - ev_base, last_code, last_break, last_ext}, {32'd1, 8'h75, 2'b11});

        send_byte(8'h23, 1'b0);
        check("remake23_kb", kb_code, 8'h23);
        mark();
        send_byte(8'h23, 1'b0);
        check("typematic_evcnt", ev_cnt - ev_base, 1);
        check("typematic_kb", kb_code, 8'h23);

        mark();
        send_byte(8'h1C, 1'b1);
        check("par_err_cnt", err_cnt - err_base, 1);
        check("par_err_width", err_wide, 0);
        check("par_err_kb", kb_code, 8'h23);
        check("par_err_noev", ev_cnt - ev_base, 0);
        send_byte(8'h1C, 1'b0);
        check("good1c_kb", kb_code, 8'h1C);

        // Start bit plus four data bits, then silence.
        mark();
        send_bits(11'b000_0000_1010, 5);
        wait_clks(TIMEOUT + 100);
        check("tmo_err_cnt", err_cnt - err_base, 1);
        check("tmo_noev", ev_cnt - ev_base, 0);
        send_byte(8'h23, 1'b0);
        check("post_tmo_kb", kb_code, 8'h23);
        check("post_tmo_ev", {last_code, last_break, last_ext}, {8'h23, 2'b00});
        check("post_tmo_errs", err_cnt - err_base, 1);

        mark();
        send_bits(11'b000_0001_0100, 4);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_kb", kb_code, 8'h00);
        check("midrst_outputs", {ev_valid, ev_code, ev_break, ev_ext, frame_err}, 12'h000);
        wait_clks(TIMEOUT + 100);
        check("midrst_noerr", err_cnt - err_base, 0);
        send_byte(8'h29, 1'b0);
        check("post_rst_kb", kb_code, 8'h29);

        // Short clock glitches with data low must not look like a start bit.
        mark();
        ps2_data = 1'b0;
        for (int g = 1; g < FILTER_LEN; g++) begin
            wait_clks(10);
            ps2_clk = 1'b0;
            wait_clks(g);
            ps2_clk = 1'b1;
        end
        wait_clks(10);
        ps2_data = 1'b1;
        wait_clks(TIMEOUT + 50);
        check("glitch_noerr", err_cnt - err_base, 0);
        send_byte(8'h34, 1'b0);
        check("glitch_kb", kb_code, 8'h34);
        check("glitch_evcnt", ev_cnt - ev_base, 1);

        check("ev_err_exclusive", both_cnt, 0);
        check("err_single_cycle", err_wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Receives PS/2 keyboard frames and decodes scan-code sequences (make, E0 extended, F0 break).
- Drives the 8-bit KB_CODE value that the processor's data-memory word 1 captures whenever no store is in progress.
- kb_code holds the currently pressed key, or 0x00 when no key is pressed; a one-cycle event strobe reports every decoded key event.
- Sits between the board PS/2 pins and the ARMV4 data memory.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized samples required before a PS/2 line level is accepted.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge before an in-progress frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data  in  1  raw PS/2 data pin (asynchronous).
- kb_code  out  8  currently held key code; 0x00 = no key pressed. Feeds KB_CODE.
- ev_valid  out  1  one-cycle pulse: a complete key event was decoded.
- ev_code  out  8  scan code of the last event; held between pulses.
- ev_break  out  1  last event was a release (F0 prefix seen); held.
- ev_ext  out  1  last event carried the E0 prefix; held.
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Reset (reset==0 at a clk edge):
  - all outputs 0; kb_code=0x00.
  - FSM to IDLE; prefix flags, bit counter and timeout counter cleared.
  - A frame in progress is discarded without a frame_err pulse.
- Input conditioning:
  - 2-FF synchronizer on both pins, then the FILTER_LEN glitch filter.
  - fall_tick is a one-cycle pulse on each accepted 1->0 transition of filtered ps2_clk.
  - Data is sampled from filtered ps2_data in the fall_tick cycle.
- FSM states (advance only on fall_tick unless noted):
  - IDLE: on fall_tick with data==0 (start bit) -> DATA, bit count 0. With data==1, stay in IDLE with no error.
  - DATA: shift in 8 bits, LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: frame is good if data==1 and ones(data bits + parity) is odd. Either way -> IDLE.
- Timeout: counter resets on every fall_tick. Outside IDLE, when it reaches TIMEOUT_CYCLES-1: frame_err pulses, FSM -> IDLE, prefix flags cleared. In IDLE the counter is held at 0.
- Errored frame: frame_err pulses the cycle after the STOP fall_tick. Prefix flags are cleared. kb_code and the ev_* outputs are unchanged.
- Decode of a good byte B (all updates land in the cycle after the STOP fall_tick):
  - B==0xE0: set ext_pending; no event.
  - B==0xF0: set brk_pending; no event.
  - Otherwise:
    - ev_code=B, ev_break=brk_pending, ev_ext=ext_pending, ev_valid=1 for one cycle.
    - Both pending flags cleared.
    - Make: kb_code=B. A repeated make of the same code (typematic) re-pulses ev_valid; kb_code value is unchanged.
    - Break with B==kb_code: kb_code=0x00.
    - Break with B!=kb_code: kb_code unchanged.
- Latency: kb_code / ev_* / frame_err update exactly 1 clk after the fall_tick that samples the stop bit.
- Pin-to-output latency adds 2 (sync) + FILTER_LEN cycles.
- ev_valid and frame_err are never asserted in the same cycle.
- Back-to-back frames:
  - The FSM returns to IDLE in the stop cycle, so the next start bit is accepted on the very next fall_tick.
  - Output updates and a new start bit in the same cycle do not interact.

Decomposition:
- Package ps2_pkg:
  - state enum ps2_state_t {IDLE, DATA, PARITY, STOP}.
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, KB_NONE=8'h00.
- Sub-module ps2_line_filter: 2-FF synchronizer and FILTER_LEN filter for both lines, producing filtered data and fall_tick. Parameter FILTER_LEN; uses the same clk and reset.
- All FSM, shift register, timeout and decode logic stays in ps2_keyboard_rx.

Test Plan:
- Frame 0x23 (parity 0, stop 1) at a 10 kHz PS/2 clock: kb_code=0x23; ev_valid pulses once with ev_code=0x23, ev_break=0, ev_ext=0; frame_err stays 0.
- Bytes 0x23, 0xF0, 0x23: after the F0/23 pair, kb_code=0x00 and exactly one ev_valid pulse with ev_break=1, ev_code=0x23. 0xF0 alone produces no event.
- Bytes 0xE0, 0x75: kb_code=0x75, ev_ext=1, ev_break=0. Then 0xE0, 0xF0, 0x75: kb_code=0x00, ev_ext=1, ev_break=1.
- Byte 0x1C with the parity bit flipped: frame_err pulses exactly 1 cycle; kb_code keeps its prior value 0x23; no ev_valid. A following good 0x1C gives kb_code=0x1C.
- Stop after 4 data bits, wait TIMEOUT_CYCLES: frame_err pulses once; FSM in IDLE. A subsequent full 0x23 frame decodes correctly.
- reset=0 for one cycle mid-frame and after kb_code=0x23: all outputs 0, kb_code=0x00, no frame_err. A later 0x29 frame gives kb_code=0x29. Single-cycle glitches on ps2_clk shorter than FILTER_LEN produce no fall_tick.
